// File: rtl/wb_commit_queue.sv
// Write-back commit queue: buffers MEM/WB register writes and drains one per cycle to the regfile.
// Optional pending-write bypass lookup for decode is enabled with `define WB_BYPASS_EN.
module wb_commit_queue #(
    parameter int         DATA_W = 64,
    parameter int         DEPTH  = 4,
    parameter logic [4:0] ZR_IDX = 5'd31
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_reg_write,
    input  logic [4:0]                 in_rd,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       wb_stall,
    output logic                       wb_reg_write,
    output logic [4:0]                 wb_register,
    output logic [DATA_W-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [4:0]                 byp_rs1,
    input  logic [4:0]                 byp_rs2,
    output logic                       byp_hit1,
    output logic                       byp_hit2,
    output logic [DATA_W-1:0]          byp_data1,
    output logic [DATA_W-1:0]          byp_data2
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    wb_ent_t        mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           full, push, pop;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
    assign in_ready = !full;
    // Non-writing and XZR requests complete the handshake but never occupy an entry.
    assign push     = in_valid && in_ready && in_reg_write && (in_rd != ZR_IDX);
    assign pop      = (count != '0) && !wb_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wb_reg_write <= 1'b0;
            wb_register  <= '0;
            wb_data      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            wb_reg_write <= pop;
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                wb_register <= mem[rd_ptr[AW-1:0]].rd;
                wb_data     <= mem[rd_ptr[AW-1:0]].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{rd: in_rd, data: in_data};
    end

`ifdef WB_BYPASS_EN
    for (genvar p = 0; p < 2; p++) begin : g_byp
        logic [4:0]        rs;
        logic              hit;
        logic [DATA_W-1:0] hdata;
        logic [AW-1:0]     idx;

        assign rs = (p == 0) ? byp_rs1 : byp_rs2;

        // Scan oldest to youngest so the last match (youngest) wins; output stage is oldest of all.
        always_comb begin
            hit   = 1'b0;
            hdata = '0;
            idx   = '0;
            if (rs != ZR_IDX) begin
                if (wb_reg_write && (wb_register == rs)) begin
                    hit   = 1'b1;
                    hdata = wb_data;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    idx = rd_ptr[AW-1:0] + AW'(i);
                    if ((PW'(i) < count) && (mem[idx].rd == rs)) begin
                        hit   = 1'b1;
                        hdata = mem[idx].data;
                    end
                end
            end
        end
    end

    assign byp_hit1  = g_byp[0].hit;
    assign byp_hit2  = g_byp[1].hit;
    assign byp_data1 = g_byp[0].hdata;
    assign byp_data2 = g_byp[1].hdata;
`else
    logic unused_byp;
    assign unused_byp = ^{byp_rs1, byp_rs2};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif
endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed scenarios plus random traffic against a queue model.
module tb_wb_commit_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_reg_write;
    logic [4:0]  in_rd;
    logic [63:0] in_data;
    logic        wb_stall, wb_reg_write;
    logic [4:0]  wb_register;
    logic [63:0] wb_data;
    logic [2:0]  count;
    logic [4:0]  byp_rs1, byp_rs2;
    logic        byp_hit1, byp_hit2;
    logic [63:0] byp_data1, byp_data2;

    always #5 clk = ~clk;

    wb_commit_queue #(.DATA_W(64), .DEPTH(DEPTH), .ZR_IDX(5'd31)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
        .in_rd(in_rd), .in_data(in_data), .wb_stall(wb_stall),
        .wb_reg_write(wb_reg_write), .wb_register(wb_register), .wb_data(wb_data),
        .count(count),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    typedef struct { logic [4:0] rd; logic [63:0] d; } ent_t;

    int          checks = 0, errors = 0;
    ent_t        q[$];
    logic [4:0]  seen[$];
    logic        e_wr;
    logic [4:0]  e_reg;
    logic [63:0] e_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_byp(input logic [4:0] rs, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 5'd31) begin
            if (e_wr && e_reg == rs) begin hit = 1'b1; d = e_data; end
            foreach (q[i]) if (q[i].rd == rs) begin hit = 1'b1; d = q[i].d; end
        end
    endtask

    task automatic chk_byp(input string tag, input logic [4:0] rs, input logic hit, input logic [63:0] d);
        logic        mh;
        logic [63:0] md;
        model_byp(rs, mh, md);
`ifdef WB_BYPASS_EN
        chk({tag, "_hit"}, hit, mh);
        if (mh) chk({tag, "_data"}, d, md);
`else
        chk({tag, "_hit"}, hit, 1'b0);
        chk({tag, "_data"}, d, 64'd0);
`endif
    endtask

    task automatic pick_rs(output logic [4:0] rs);
        if (q.size() != 0 && $urandom_range(0, 1) == 1) rs = q[$urandom_range(0, q.size() - 1)].rd;
        else rs = 5'($urandom_range(0, 31));
    endtask

    task automatic compare_all();
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", in_ready, q.size() != DEPTH);
        chk("wb_reg_write", wb_reg_write, e_wr);
        chk("wb_register", wb_register, e_reg);
        chk("wb_data", wb_data, e_data);
        if (wb_reg_write) seen.push_back(wb_register);
        pick_rs(byp_rs1);
        pick_rs(byp_rs2);
        #1;
        chk_byp("byp1", byp_rs1, byp_hit1, byp_data1);
        chk_byp("byp2", byp_rs2, byp_hit2, byp_data2);
    endtask

    // One clock: drive request, update the reference at the edge, check at the falling edge.
    task automatic cyc(input logic v, input logic rw, input logic [4:0] rd, input logic [63:0] d, input logic st);
        int   n;
        bit   rdy;
        ent_t h;
        in_valid = v; in_reg_write = rw; in_rd = rd; in_data = d; wb_stall = st;
        @(posedge clk);
        n   = q.size();
        rdy = (n != DEPTH);
        if (n != 0 && !st) begin
            h = q.pop_front();
            e_wr = 1'b1; e_reg = h.rd; e_data = h.d;
        end else e_wr = 1'b0;
        if (v && rdy && rw && rd != 5'd31) q.push_back('{rd, d});
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
    endtask

    initial begin
        logic [4:0] exp_rd[$];
        rst_n = 1'b0; in_valid = 0; in_reg_write = 0; in_rd = 0; in_data = 0; wb_stall = 0;
        byp_rs1 = 0; byp_rs2 = 0;
        e_wr = 0; e_reg = 0; e_data = 0;
        #2;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // single write, two-edge latency, one-cycle pulse
        cyc(1, 1, 5'd5, 64'hDEAD_BEEF, 0);
        chk("lat_n1_wr", wb_reg_write, 1'b0);
        cyc(0, 0, 0, 0, 0);
        chk("lat_n2_wr", wb_reg_write, 1'b1);
        chk("lat_n2_reg", wb_register, 5'd5);
        chk("lat_n2_data", wb_data, 64'hDEAD_BEEF);
        cyc(0, 0, 0, 0, 0);
        chk("lat_n3_wr", wb_reg_write, 1'b0);
        chk("lat_n3_cnt", count, 3'd0);

        // stalled fill, then ordered drain
        seen.delete();
        for (int i = 1; i <= 4; i++) cyc(1, 1, 5'(i), 64'(i * 16), 1);
        chk("full_ready", in_ready, 1'b0);
        chk("full_count", count, 3'd4);
        cyc(1, 1, 5'd5, 64'h50, 1);
        chk("full_hold", count, 3'd4);
        cyc(1, 1, 5'd5, 64'h50, 0);
        chk("pop_no_pushthru", count, 3'd3);
        cyc(1, 1, 5'd5, 64'h50, 0);
        idle(6);
        chk("drain_n", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk($sformatf("drain_ord%0d", i), seen[i], 5'(i + 1));

        // XZR and non-writing requests are swallowed
        seen.delete();
        cyc(1, 1, 5'd31, 64'd7, 0);
        chk("xzr_cnt", count, 3'd0);
        cyc(1, 0, 5'd2, 64'd9, 0);
        chk("norw_cnt", count, 3'd0);
        idle(3);
        chk("swallow_nowrite", seen.size(), 0);

        // bypass: youngest of two same-rd entries wins, XZR never hits
        cyc(1, 1, 5'd3, 64'hA, 1);
        cyc(1, 1, 5'd3, 64'hB, 1);
        byp_rs1 = 5'd3; byp_rs2 = 5'd31;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_young_hit", byp_hit1, 1'b1);
        chk("byp_young_data", byp_data1, 64'hB);
`else
        chk("byp_off_hit", byp_hit1, 1'b0);
        chk("byp_off_data", byp_data1, 64'd0);
`endif
        chk("byp_xzr_hit", byp_hit2, 1'b0);
        idle(4);

        // asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1, 1, 5'(10 + i), 64'(100 + i), 1);
        cyc(0, 0, 0, 0, 0);
        chk("pre_rst_wr", wb_reg_write, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_cnt", count, 3'd0);
        chk("rst_async_wr", wb_reg_write, 1'b0);
        chk("rst_async_reg", wb_register, 5'd0);
        q.delete(); e_wr = 0; e_reg = 0; e_data = 0;
        #1;
        rst_n = 1'b1;
        seen.delete();
        idle(4);
        chk("rst_no_stale", seen.size(), 0);

        // continuous streaming through pointer wrap
        seen.delete();
        exp_rd.delete();
        for (int i = 0; i < 20; i++) begin
            exp_rd.push_back(5'((i % 30) + 1));
            cyc(1, 1, 5'((i % 30) + 1), {$urandom, $urandom}, 0);
            chk("stream_cnt_le2", count <= 3'd2, 1'b1);
        end
        idle(3);
        chk("stream_n", seen.size(), 20);
        for (int i = 0; i < 20 && i < seen.size(); i++) chk($sformatf("stream_ord%0d", i), seen[i], exp_rd[i]);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0), rd,
                {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0));
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
